pixel_serializer: RTL and testbench

Converts the frame grabber's wide multi-pixel Mono8 bursts into a one-pixel-per-cycle AXI stream, tagging each pixel with its row/column position. Sits between the CoaxLink data path and `crop_norm`, driving its `s_axis_*`, `cnt_col`, `cnt_row` and `seq_ap_idle` inputs. Runs one frame per `ap_start` under ap_ctrl handshaking.

---
 rtl/pixel_serializer_pkg.sv | 20 ++
 rtl/pixel_serializer_pos_counter.sv | 46 ++++
 rtl/pixel_serializer.sv | 139 +++++++++++++
 tb/tb_pixel_serializer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_serializer_pkg.sv
// Shared types for the burst-to-pixel serializer and its position counter.
// Pixel width, FSM state encoding and a width helper for small parameters.
package pixel_serializer_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // $clog2 collapses to 0 for a single-entry range; keep every counter at least 1 bit.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_serializer_pos_counter.sv
// Raster position counter: column/row of the current pixel, advanced per handshake.
// Zero latency on is_last (combinational from the registers); clr wins over inc.
module pixel_pos_counter
  import pixel_serializer_pkg::*;
#(
  parameter int  IN_ROWS = 20,
  parameter int  IN_COLS = 20,
  localparam int COL_W   = safe_clog2(IN_COLS),
  localparam int ROW_W   = safe_clog2(IN_ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] cnt_col,
  output logic [ROW_W-1:0] cnt_row,
  output logic             is_last
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_end;
  logic             w_row_end;

  assign w_col_end = (r_col == COL_W'(IN_COLS - 1));
  assign w_row_end = (r_row == ROW_W'(IN_ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign cnt_col = r_col;
  assign cnt_row = r_row;
  assign is_last = w_col_end && w_row_end;

endmodule

// File: rtl/pixel_serializer.sv
// Splits Mono8 burst words into one tagged pixel per cycle, one frame per ap_start.
// Pixel 0 one cycle after word accept; stalls hold outputs, next word loads with no bubble.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int  IN_ROWS          = 20,
  parameter int  IN_COLS          = 20,
  parameter int  PIXELS_PER_BURST = 4,
  localparam int COL_W            = safe_clog2(IN_COLS),
  localparam int ROW_W            = safe_clog2(IN_ROWS),
  localparam int WORD_W           = PIXELS_PER_BURST * PIXEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [WORD_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [PIXEL_W-1:0] m_axis_tdata,
  output logic [COL_W-1:0]  cnt_col,
  output logic [ROW_W-1:0]  cnt_row,
  output logic              m_axis_tlast
);

  localparam int TOTAL_WORDS = (IN_ROWS * IN_COLS) / PIXELS_PER_BURST;
  localparam int WCNT_W      = $clog2(TOTAL_WORDS + 1);
  localparam int IDX_W       = safe_clog2(PIXELS_PER_BURST);

  ser_state_t r_state;
  ser_state_t w_state_nxt;

  pixel_t [PIXELS_PER_BURST-1:0] r_word;
  logic                          r_word_valid;
  logic [IDX_W-1:0]              r_pix_idx;
  logic [WCNT_W-1:0]             r_word_cnt;

  logic w_start;
  logic w_pix_hs;
  logic w_last_pix;
  logic w_word_acc;
  logic w_pos_last;
  logic w_frame_end;
  logic w_words_left;

  assign w_pix_hs     = r_word_valid && m_axis_tready;
  assign w_last_pix   = w_pix_hs && (r_pix_idx == IDX_W'(PIXELS_PER_BURST - 1));
  assign w_frame_end  = w_pix_hs && w_pos_last;
  assign w_words_left = (r_word_cnt < WCNT_W'(TOTAL_WORDS));

  // A word may enter only when the register is empty or draining its last pixel this cycle.
  assign s_axis_tready = (r_state == RUN) && w_words_left && (!r_word_valid || w_last_pix);
  assign w_word_acc    = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    ap_idle     = 1'b0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    case (r_state)
      IDLE: begin
        ap_idle  = 1'b1;
        ap_ready = 1'b1;
        if (ap_start) begin
          w_start     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_frame_end) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        ap_done     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_pix_idx    <= '0;
      r_word_cnt   <= '0;
    end else if (w_start) begin
      r_word_valid <= 1'b0;
      r_pix_idx    <= '0;
      r_word_cnt   <= '0;
    end else if (w_word_acc) begin
      r_word       <= s_axis_tdata;
      r_word_valid <= 1'b1;
      r_pix_idx    <= '0;
      r_word_cnt   <= r_word_cnt + 1'b1;
    end else if (w_pix_hs) begin
      if (w_last_pix) begin
        r_pix_idx    <= '0;
        r_word_valid <= 1'b0;
      end else begin
        r_pix_idx <= r_pix_idx + 1'b1;
      end
    end
  end

  pixel_pos_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_start),
    .inc     (w_pix_hs),
    .cnt_col (cnt_col),
    .cnt_row (cnt_row),
    .is_last (w_pos_last)
  );

  assign m_axis_tvalid = r_word_valid;
  assign m_axis_tdata  = r_word[r_pix_idx];
  assign m_axis_tlast  = r_word_valid && w_pos_last;

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer at 4x8 frame, 4 pixels per burst (8 words, 32 pixels).
module tb_pixel_serializer;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int PPB   = 4;
  localparam int NPIX  = ROWS * COLS;
  localparam int NWORD = NPIX / PPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_ready, ap_idle;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [2:0]  cnt_col;
  logic [1:0]  cnt_row;
  logic        m_axis_tlast;

  pixel_serializer #(
    .IN_ROWS          (ROWS),
    .IN_COLS          (COLS),
    .PIXELS_PER_BURST (PPB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .ap_idle       (ap_idle),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .cnt_col       (cnt_col),
    .cnt_row       (cnt_row),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] c;
    logic [1:0] r;
    logic       l;
  } pix_t;

  typedef struct {
    string name;
    int    rdy_mode;   // 0: always ready, 1: ready pattern 1,0,0
    int    gap_after;  // words accepted before the upstream gap, -1 for none
    int    gap_len;
    int    exp_low;    // cycles with tvalid low between first and last pixel
    int    exp_span;   // cycles from first valid pixel to last handshake, -1 unchecked
  } scen_t;

  int tests = 0;
  int fails = 0;

  pix_t        exp_q[$];
  logic [31:0] src[$];
  int  rdy_mode, rcyc, gap_after, gap_len, gap_cnt;
  int  acc_words, ex_pix, popped, cyc;
  int  last_hs_cyc, done_cyc, done_cnt, word3_cyc, resume_cyc, low_cycles, first_v_cyc;
  logic [7:0] first_d;
  logic [2:0] first_c;
  logic [1:0] first_r;
  bit  start_req, rst_req;
  bit  prev_stall;
  logic [7:0] prev_d;
  logic [2:0] prev_c;
  logic [1:0] prev_r;
  logic       prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_words(input int n);
    for (int k = 0; k < n; k++)
      src.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
  endtask

  task automatic cycle();
    pix_t e;
    logic [31:0] w;
    @(negedge clk);
    reset    = rst_req;
    ap_start = start_req;
    start_req = 1'b0;
    m_axis_tready = (rdy_mode == 0) || (rcyc % 3 == 0);
    rcyc++;
    if (gap_cnt > 0) begin
      s_axis_tvalid = 1'b0;
      gap_cnt--;
    end else begin
      s_axis_tvalid = (src.size() > 0);
    end
    s_axis_tdata = (src.size() > 0) ? src[0] : 32'h0;
    #1;
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("hold_data",  32'(m_axis_tdata), 32'(prev_d));
      chk("hold_col",   32'(cnt_col), 32'(prev_c));
      chk("hold_row",   32'(cnt_row), 32'(prev_r));
      chk("hold_last",  32'(m_axis_tlast), 32'(prev_l));
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d = m_axis_tdata;
    prev_c = cnt_col;
    prev_r = cnt_row;
    prev_l = m_axis_tlast;
    if (ap_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_axis_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
    if (popped > 0 && popped < NPIX && !m_axis_tvalid) low_cycles++;
    if (m_axis_tvalid && popped == 12 && resume_cyc < 0) resume_cyc = cyc;
    if (s_axis_tvalid && s_axis_tready) begin
      w = src.pop_front();
      for (int p = 0; p < PPB; p++) begin
        e.d = w[8*p +: 8];
        e.c = 3'(ex_pix % COLS);
        e.r = 2'(ex_pix / COLS);
        e.l = (ex_pix == NPIX - 1);
        exp_q.push_back(e);
        ex_pix++;
      end
      acc_words++;
      if (acc_words == gap_after + 1) gap_cnt = gap_len;
      if (acc_words == 4) word3_cyc = cyc;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (popped == 0) begin
          first_d = m_axis_tdata;
          first_c = cnt_col;
          first_r = cnt_row;
        end
        chk("pix_data", 32'(m_axis_tdata), 32'(e.d));
        chk("pix_col",  32'(cnt_col), 32'(e.c));
        chk("pix_row",  32'(cnt_row), 32'(e.r));
        chk("pix_last", 32'(m_axis_tlast), 32'(e.l));
        if (e.l) last_hs_cyc = cyc;
      end
      popped++;
    end
  endtask

  task automatic frame_init(input int rmode, input int gafter, input int glen);
    rdy_mode = rmode; gap_after = gafter; gap_len = glen; gap_cnt = 0;
    rcyc = 0; acc_words = 0; ex_pix = 0; popped = 0;
    last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; word3_cyc = -1;
    resume_cyc = -1; low_cycles = 0; first_v_cyc = -1;
  endtask

  task automatic run_frame(input string tag);
    int n;
    start_req = 1'b1;
    cycle();
    cycle();
    chk({tag, "_start_tready"}, 32'(s_axis_tready), 32'd1);
    chk({tag, "_start_idle"}, 32'(ap_idle), 32'd0);
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      cycle();
      n++;
    end
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    chk({tag, "_pixels"}, 32'(popped), 32'(NPIX));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_lat"}, 32'(done_cyc - last_hs_cyc), 32'd1);
    cycle();
    chk({tag, "_done_pulse"}, 32'(ap_done), 32'd0);
    chk({tag, "_back_idle"}, 32'(ap_idle), 32'd1);
    chk({tag, "_idle_tready"}, 32'(s_axis_tready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ap_idle"},  32'(ap_idle), 32'd1);
    chk({tag, "_ap_ready"}, 32'(ap_ready), 32'd1);
    chk({tag, "_ap_done"},  32'(ap_done), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_m_tlast"},  32'(m_axis_tlast), 32'd0);
    chk({tag, "_m_tdata"},  32'(m_axis_tdata), 32'd0);
    chk({tag, "_cnt_col"},  32'(cnt_col), 32'd0);
    chk({tag, "_cnt_row"},  32'(cnt_row), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t scen[3];
    int n;
    // gap of 5 cycles: 3 are hidden behind the 4 pixels of word 2, leaving a 2-cycle bubble
    scen[0] = '{name: "stream", rdy_mode: 0, gap_after: -1, gap_len: 0, exp_low: 0, exp_span: NPIX - 1};
    scen[1] = '{name: "bpress", rdy_mode: 1, gap_after: -1, gap_len: 0, exp_low: 0, exp_span: -1};
    scen[2] = '{name: "gap",    rdy_mode: 0, gap_after: 2,  gap_len: 5, exp_low: 2, exp_span: -1};

    cyc = 0; start_req = 1'b0; prev_stall = 1'b0;
    frame_init(0, -1, 0);
    rst_req = 1'b1;
    repeat (3) cycle();
    check_reset_vals("reset");
    rst_req = 1'b0;
    cycle();

    for (int i = 0; i < 3; i++) begin
      frame_init(scen[i].rdy_mode, scen[i].gap_after, scen[i].gap_len);
      load_words(NWORD);
      run_frame(scen[i].name);
      chk({scen[i].name, "_low_cycles"}, 32'(low_cycles), 32'(scen[i].exp_low));
      if (scen[i].exp_span >= 0)
        chk({scen[i].name, "_span"}, 32'(last_hs_cyc - first_v_cyc), 32'(scen[i].exp_span));
      if (scen[i].gap_after >= 0)
        chk({scen[i].name, "_resume_lat"}, 32'(resume_cyc - word3_cyc), 32'd1);
    end

    // frame boundary: a surplus word must survive into the next frame
    frame_init(0, -1, 0);
    load_words(NWORD);
    src.push_back(32'hAAAA_AAAA);
    run_frame("bound1");
    chk("bound_surplus_kept", 32'(src.size()), 32'd1);
    repeat (3) begin
      cycle();
      chk("bound_idle_tready", 32'(s_axis_tready), 32'd0);
    end
    frame_init(0, -1, 0);
    for (int k = 1; k < NWORD; k++)
      src.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    run_frame("bound2");
    chk("bound_first_data", 32'(first_d), 32'hAA);
    chk("bound_first_col", 32'(first_c), 32'd0);
    chk("bound_first_row", 32'(first_r), 32'd0);

    // mid-frame reset after pixel 13
    frame_init(0, -1, 0);
    load_words(NWORD);
    start_req = 1'b1;
    cycle();
    n = 0;
    while (popped < 14 && n < 200) begin
      cycle();
      n++;
    end
    chk("midrst_pre_pixels", 32'(popped), 32'd14);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check_reset_vals("midrst");
    exp_q.delete();
    src.delete();
    frame_init(0, -1, 0);
    load_words(NWORD);
    run_frame("restart");
    chk("restart_first_data", 32'(first_d), 32'h00);
    chk("restart_first_col", 32'(first_c), 32'd0);
    chk("restart_first_row", 32'(first_r), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
